// File: rtl/e203_mdv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
// Holds the op and state encodings plus a few small op-decode helpers.
package e203_mdv_pkg;

    localparam int XLEN      = 32;
    localparam int MDV_BEATS = 32;
    localparam int CNT_W     = 6;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } mdv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_CORR = 2'd2,
        ST_DONE = 2'd3
    } mdv_state_e;

    function automatic logic mdv_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic mdv_is_rem(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    function automatic logic mdv_is_sdiv(input logic [2:0] op);
        return op[2] & ~op[0];
    endfunction

endpackage

// File: rtl/e203_exu_alu_muldiv_spcl.sv
// Combinational detection of operations that finish without the iterative datapath:
// divide by zero, signed divide overflow and reuse of a previous MULH* low product.
module e203_exu_alu_muldiv_spcl
    import e203_mdv_pkg::*;
(
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            mdv_nob2b,
    input  logic            rec_vld,
    input  logic [XLEN-1:0] rec_rs1,
    input  logic [XLEN-1:0] rec_rs2,
    input  logic [XLEN-1:0] rec_lo,
    output logic            div_by_zero,
    output logic            div_ovf,
    output logic            b2b_hit,
    output logic            spcl_hit,
    output logic [XLEN-1:0] spcl_res
);

    always_comb begin
        div_by_zero = mdv_is_div(op) && (rs2 == '0);
        div_ovf     = mdv_is_sdiv(op) && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
        b2b_hit     = (op == OP_MUL) && !mdv_nob2b && rec_vld
                      && (rs1 == rec_rs1) && (rs2 == rec_rs2);
        spcl_hit    = div_by_zero || div_ovf || b2b_hit;
        spcl_res    = '0;
        // Divide by zero takes priority: overflow needs a nonzero divisor anyway.
        if (div_by_zero) begin
            spcl_res = mdv_is_rem(op) ? rs1 : '1;
        end else if (div_ovf) begin
            spcl_res = mdv_is_rem(op) ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end else if (b2b_hit) begin
            spcl_res = rec_lo;
        end
    end

endmodule

// File: rtl/e203_exu_alu_muldiv_seq.sv
// Sequential RISC-V M-extension unit: shift-add multiply and non-restoring divide,
// one beat per granted use of a shared 34-bit adder, 33 beats over 33-bit operands.
module e203_exu_alu_muldiv_seq
    import e203_mdv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_valid,
    output logic            i_ready,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic            mdv_nob2b,
    input  logic            flush_pulse,
    output logic            dp_req,
    input  logic            dp_gnt,
    output logic [33:0]     dp_op1,
    output logic [33:0]     dp_op2,
    output logic            dp_sub,
    input  logic [33:0]     dp_res,
    output logic            o_valid,
    input  logic            o_ready,
    output logic [XLEN-1:0] o_wdat
);

    mdv_state_e       state_q, state_d;
    mdv_op_e          op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  rs1_q, rs2_q;
    logic [XLEN:0]    opnd_q, hi_q, lo_q;
    logic [XLEN:0]    hi_d, lo_d;
    logic             quo_neg_q, rem_neg_q;
    logic             rec_vld_q;
    logic [XLEN-1:0]  rec_rs1_q, rec_rs2_q, rec_lo_q;

    logic             accept, last_beat;
    logic             div_by_zero, div_ovf, b2b_hit, spcl_hit;
    logic [XLEN-1:0]  spcl_res;
    logic [XLEN:0]    init_opnd, init_lo;
    logic             init_quo_neg, init_rem_neg;
    logic [XLEN-1:0]  mul_res, corr_res, rem_fix;

    assign i_ready   = (state_q == ST_IDLE);
    assign o_valid   = (state_q == ST_DONE);
    assign dp_req    = (state_q == ST_EXEC) || (state_q == ST_CORR);
    assign accept    = i_valid && i_ready && !flush_pulse;
    assign last_beat = (cnt_q == CNT_W'(MDV_BEATS));

    e203_exu_alu_muldiv_spcl u_spcl (
        .op          (i_op),
        .rs1         (i_rs1),
        .rs2         (i_rs2),
        .mdv_nob2b   (mdv_nob2b),
        .rec_vld     (rec_vld_q),
        .rec_rs1     (rec_rs1_q),
        .rec_rs2     (rec_rs2_q),
        .rec_lo      (rec_lo_q),
        .div_by_zero (div_by_zero),
        .div_ovf     (div_ovf),
        .b2b_hit     (b2b_hit),
        .spcl_hit    (spcl_hit),
        .spcl_res    (spcl_res)
    );

    // Multiply keeps the extended multiplicand in opnd and the multiplier in lo;
    // divide keeps the divisor magnitude in opnd and the dividend magnitude in lo.
    always_comb begin
        init_opnd    = '0;
        init_lo      = '0;
        init_quo_neg = 1'b0;
        init_rem_neg = 1'b0;
        if (mdv_is_div(i_op)) begin
            init_quo_neg = mdv_is_sdiv(i_op) && (i_rs1[XLEN-1] ^ i_rs2[XLEN-1]);
            init_rem_neg = mdv_is_sdiv(i_op) && i_rs1[XLEN-1];
            init_opnd    = {1'b0, (mdv_is_sdiv(i_op) && i_rs2[XLEN-1]) ? -i_rs2 : i_rs2};
            init_lo      = {1'b0, (mdv_is_sdiv(i_op) && i_rs1[XLEN-1]) ? -i_rs1 : i_rs1};
        end else begin
            init_opnd = {(i_op != OP_MULHU) && i_rs1[XLEN-1], i_rs1};
            init_lo   = {!i_op[1] && i_rs2[XLEN-1], i_rs2};
        end
    end

    always_comb begin
        dp_op1   = '0;
        dp_op2   = '0;
        dp_sub   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        rem_fix  = '0;
        corr_res = '0;
        if (state_q == ST_EXEC) begin
            if (!mdv_is_div(op_q)) begin
                // The final beat weighs the multiplier sign bit negatively.
                dp_op1 = {hi_q[XLEN], hi_q};
                dp_op2 = lo_q[0] ? {opnd_q[XLEN], opnd_q} : '0;
                dp_sub = last_beat;
                hi_d   = dp_res[33:1];
                lo_d   = {dp_res[0], lo_q[XLEN:1]};
            end else begin
                dp_op1 = {hi_q, lo_q[XLEN]};
                dp_op2 = {1'b0, opnd_q};
                dp_sub = !hi_q[XLEN];
                hi_d   = dp_res[XLEN:0];
                lo_d   = {lo_q[XLEN-1:0], !dp_res[33]};
            end
        end else if (state_q == ST_CORR) begin
            if (mdv_is_rem(op_q)) begin
                dp_op1   = {hi_q[XLEN], hi_q};
                dp_op2   = hi_q[XLEN] ? {1'b0, opnd_q} : '0;
                rem_fix  = dp_res[XLEN-1:0];
                corr_res = rem_neg_q ? -rem_fix : rem_fix;
            end else begin
                dp_op2   = {2'b00, lo_q[XLEN-1:0]};
                dp_sub   = quo_neg_q;
                corr_res = dp_res[XLEN-1:0];
            end
        end
        mul_res = (op_q == OP_MUL) ? lo_d[XLEN-1:0] : {hi_d[XLEN-2:0], lo_d[XLEN]};
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = spcl_hit ? ST_DONE : ST_EXEC;
            ST_EXEC: if (dp_gnt && last_beat) state_d = mdv_is_div(op_q) ? ST_CORR : ST_DONE;
            ST_CORR: if (dp_gnt) state_d = ST_DONE;
            ST_DONE: if (o_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush_pulse && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OP_MUL;
            cnt_q     <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            o_wdat    <= '0;
        end else if (accept) begin
            op_q      <= mdv_op_e'(i_op);
            cnt_q     <= '0;
            rs1_q     <= i_rs1;
            rs2_q     <= i_rs2;
            opnd_q    <= init_opnd;
            hi_q      <= '0;
            lo_q      <= init_lo;
            quo_neg_q <= init_quo_neg;
            rem_neg_q <= init_rem_neg;
            if (spcl_hit) begin
                o_wdat <= spcl_res;
            end
        end else if ((state_q == ST_EXEC) && dp_gnt) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_beat && !mdv_is_div(op_q)) begin
                o_wdat <= mul_res;
            end
        end else if ((state_q == ST_CORR) && dp_gnt) begin
            o_wdat <= corr_res;
        end
    end

    // Only a completed high-half multiply leaves a reusable low product behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rec_vld_q <= 1'b0;
            rec_rs1_q <= '0;
            rec_rs2_q <= '0;
            rec_lo_q  <= '0;
        end else if (flush_pulse) begin
            rec_vld_q <= 1'b0;
        end else if (o_valid && o_ready) begin
            rec_vld_q <= !mdv_is_div(op_q) && (op_q != OP_MUL);
            rec_rs1_q <= rs1_q;
            rec_rs2_q <= rs2_q;
            rec_lo_q  <= lo_q[XLEN-1:0];
        end
    end

endmodule

// File: tb/tb_e203_exu_alu_muldiv_seq.sv
// Directed self-checking bench for the sequential mul/div unit with a modelled shared adder.
module tb_e203_exu_alu_muldiv_seq;
    import e203_mdv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_ready;
    logic [2:0]  i_op = 3'd0;
    logic [31:0] i_rs1 = '0;
    logic [31:0] i_rs2 = '0;
    logic        mdv_nob2b = 1'b0;
    logic        flush_pulse = 1'b0;
    logic        dp_req;
    logic        dp_gnt = 1'b1;
    logic [33:0] dp_op1, dp_op2, dp_res;
    logic        dp_sub;
    logic        o_valid;
    logic        o_ready = 1'b0;
    logic [31:0] o_wdat;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign dp_res = dp_sub ? (dp_op1 - dp_op2) : (dp_op1 + dp_op2);

    e203_exu_alu_muldiv_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_valid     (i_valid),
        .i_ready     (i_ready),
        .i_op        (i_op),
        .i_rs1       (i_rs1),
        .i_rs2       (i_rs2),
        .mdv_nob2b   (mdv_nob2b),
        .flush_pulse (flush_pulse),
        .dp_req      (dp_req),
        .dp_gnt      (dp_gnt),
        .dp_op1      (dp_op1),
        .dp_op2      (dp_op2),
        .dp_sub      (dp_sub),
        .dp_res      (dp_res),
        .o_valid     (o_valid),
        .o_ready     (o_ready),
        .o_wdat      (o_wdat)
    );

    // Offer one op; returns 1ns after the accepting edge
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        i_valid = 1'b1;
        i_op    = op;
        i_rs1   = a;
        i_rs2   = b;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    // Edges after acceptance until o_valid, and cycles with dp_req high
    task automatic wait_result(input bit toggle, output int edges, output int reqs, output logic [31:0] dat);
        edges = 0;
        reqs  = 0;
        while (!o_valid && edges < 200) begin
            dp_gnt = toggle ? edges[0] : 1'b1;
            if (dp_req) reqs++;
            @(posedge clk);
            #1;
            edges++;
        end
        dp_gnt = 1'b1;
        dat = o_wdat;
    endtask

    task automatic consume();
        @(negedge clk);
        o_ready = 1'b1;
        @(posedge clk);
        #1;
        o_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_o_valid: got %b expected 0", o_valid); end
        n_checks++; if (o_wdat !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_o_wdat: got %h expected 00000000", o_wdat); end
        n_checks++; if (dp_req !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_dp_req: got %b expected 0", dp_req); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (i_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_i_ready: got %b expected 1", i_ready); end
        n_checks++; if ({dp_op1, dp_op2, dp_sub} !== 69'h0) begin n_fail++; $display("[TB] FAIL reset_dp_ops: got %h/%h/%b expected 0", dp_op1, dp_op2, dp_sub); end
    endtask

    task automatic test_mul();
        logic [2:0]  ops [5] = '{OP_MUL, OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
        logic [31:0] as  [5] = '{32'd7, 32'h12345678, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] bs  [5] = '{32'd6, 32'h00000010, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exp [5] = '{32'h0000002A, 32'h23456780, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE};
        int edges, reqs;
        logic [31:0] dat;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(ops[i], as[i], bs[i]);
            wait_result(1'b0, edges, reqs, dat);
            n_checks++; if (dat !== exp[i]) begin n_fail++; $display("[TB] FAIL mul_data[%0d]: got %h expected %h", i, dat, exp[i]); end
            n_checks++; if (edges !== 33) begin n_fail++; $display("[TB] FAIL mul_latency[%0d]: got %0d expected 33", i, edges); end
            if (i == 0) begin
                repeat (3) @(posedge clk);
                #1;
                n_checks++; if ({o_valid, o_wdat} !== {1'b1, 32'h2A}) begin n_fail++; $display("[TB] FAIL done_hold: got %b/%h expected 1/0000002a", o_valid, o_wdat); end
            end
            consume();
        end
        n_checks++; if ({i_ready, dp_req, dp_op1, dp_op2, dp_sub} !== {2'b10, 69'h0}) begin n_fail++; $display("[TB] FAIL idle_after_mul: got rdy=%b req=%b ops=%h/%h/%b expected rdy=1 rest 0", i_ready, dp_req, dp_op1, dp_op2, dp_sub); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops [7] = '{OP_MULH, OP_MUL, OP_MULHU, OP_MUL, OP_MULH, OP_DIVU, OP_MUL};
        logic [31:0] as  [7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd3, 32'd9, 32'd3};
        logic [31:0] bs  [7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd3, 32'd5};
        logic        nob [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] exp [7] = '{32'h0, 32'h1, 32'hFFFFFFFE, 32'h1, 32'h0, 32'h3, 32'd15};
        int          lat [7] = '{33, 0, 33, 33, 33, 34, 33};
        int edges, reqs;
        logic [31:0] dat;
        for (int i = 0; i < 7; i++) begin
            mdv_nob2b = nob[i];
            applyStimulus(ops[i], as[i], bs[i]);
            wait_result(1'b0, edges, reqs, dat);
            n_checks++; if (dat !== exp[i]) begin n_fail++; $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", i, dat, exp[i]); end
            n_checks++; if (edges !== lat[i]) begin n_fail++; $display("[TB] FAIL b2b_latency[%0d]: got %0d expected %0d", i, edges, lat[i]); end
            if (i == 1) begin
                n_checks++; if (reqs !== 0) begin n_fail++; $display("[TB] FAIL b2b_no_dp_req: got %0d request cycles expected 0", reqs); end
            end
            consume();
        end
        mdv_nob2b = 1'b0;
    endtask

    task automatic test_div();
        logic [2:0]  ops [6] = '{OP_DIV, OP_REM, OP_REM, OP_DIV, OP_DIVU, OP_REMU};
        logic [31:0] as  [6] = '{32'd100, 32'd100, -32'd100, -32'd100, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] bs  [6] = '{-32'd7, -32'd7, 32'd7, -32'd7, 32'd1, 32'h10};
        logic [31:0] exp [6] = '{32'hFFFFFFF2, 32'h2, 32'hFFFFFFFE, 32'hE, 32'hFFFFFFFF, 32'hF};
        int edges, reqs;
        logic [31:0] dat;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(ops[i], as[i], bs[i]);
            wait_result(1'b0, edges, reqs, dat);
            n_checks++; if (dat !== exp[i]) begin n_fail++; $display("[TB] FAIL div_data[%0d]: got %h expected %h", i, dat, exp[i]); end
            n_checks++; if (edges !== 34) begin n_fail++; $display("[TB] FAIL div_latency[%0d]: got %0d expected 34", i, edges); end
            consume();
        end
    endtask

    task automatic test_special();
        logic [2:0]  ops [4] = '{OP_DIVU, OP_REMU, OP_REM, OP_DIV};
        logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exp [4] = '{32'hFFFFFFFF, 32'h5, 32'h0, 32'h80000000};
        int edges, reqs;
        logic [31:0] dat;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(ops[i], as[i], bs[i]);
            wait_result(1'b0, edges, reqs, dat);
            n_checks++; if (dat !== exp[i]) begin n_fail++; $display("[TB] FAIL spcl_data[%0d]: got %h expected %h", i, dat, exp[i]); end
            n_checks++; if ({edges, reqs} !== {32'd0, 32'd0}) begin n_fail++; $display("[TB] FAIL spcl_timing[%0d]: got edges=%0d reqs=%0d expected 0/0", i, edges, reqs); end
            n_checks++; if ({dp_req, dp_op1, dp_op2, dp_sub} !== 70'h0) begin n_fail++; $display("[TB] FAIL spcl_dp_idle[%0d]: got req=%b ops=%h/%h/%b expected 0", i, dp_req, dp_op1, dp_op2, dp_sub); end
            consume();
        end
    endtask

    task automatic test_gnt_stall();
        int edges, reqs;
        logic [31:0] dat;
        applyStimulus(OP_DIVU, 32'd100, 32'd7);
        wait_result(1'b1, edges, reqs, dat);
        n_checks++; if (dat !== 32'hE) begin n_fail++; $display("[TB] FAIL stall_data: got %h expected 0000000e", dat); end
        n_checks++; if (reqs !== 68) begin n_fail++; $display("[TB] FAIL stall_req_cycles: got %0d expected 68", reqs); end
        n_checks++; if (edges !== 68) begin n_fail++; $display("[TB] FAIL stall_latency: got %0d expected 68", edges); end
        consume();
    endtask

    task automatic test_flush();
        int edges, reqs;
        logic [31:0] dat;
        bit seen = 1'b0;
        applyStimulus(OP_MULHU, 32'hDEADBEEF, 32'h12345678);
        repeat (10) @(posedge clk);
        #1;
        flush_pulse = 1'b1;
        @(posedge clk);
        #1;
        flush_pulse = 1'b0;
        n_checks++; if ({o_valid, i_ready, dp_req} !== 3'b010) begin n_fail++; $display("[TB] FAIL flush_exec: got valid=%b rdy=%b req=%b expected 0/1/0", o_valid, i_ready, dp_req); end
        // A flush in IDLE must block the same-cycle offer
        @(negedge clk);
        flush_pulse = 1'b1;
        i_valid     = 1'b1;
        i_op        = OP_MUL;
        i_rs1       = 32'd4;
        i_rs2       = 32'd4;
        @(posedge clk);
        #1;
        flush_pulse = 1'b0;
        i_valid     = 1'b0;
        n_checks++; if ({i_ready, dp_req} !== 2'b10) begin n_fail++; $display("[TB] FAIL flush_idle_accept: got rdy=%b req=%b expected 1/0", i_ready, dp_req); end
        repeat (40) begin
            @(posedge clk);
            #1;
            if (o_valid) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_no_output: got o_valid seen=%b expected 0", seen); end
        applyStimulus(OP_MUL, 32'd3, 32'd3);
        wait_result(1'b0, edges, reqs, dat);
        n_checks++; if (dat !== 32'd9) begin n_fail++; $display("[TB] FAIL flush_next_mul: got %h expected 00000009", dat); end
        consume();
    endtask

    task automatic test_reset_midop();
        int edges, reqs;
        logic [31:0] dat;
        bit seen = 1'b0;
        applyStimulus(OP_MULH, 32'd11, 32'd13);
        wait_result(1'b0, edges, reqs, dat);
        consume();
        applyStimulus(OP_MUL, 32'd11, 32'd12);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({o_valid, dp_req, i_ready, o_wdat} !== {3'b001, 32'h0}) begin n_fail++; $display("[TB] FAIL async_reset: got valid=%b req=%b rdy=%b wdat=%h expected 0/0/1/0", o_valid, dp_req, i_ready, o_wdat); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (o_valid) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_discard: got o_valid seen=%b expected 0", seen); end
        // The MULH record from before reset must no longer shortcut
        applyStimulus(OP_MUL, 32'd11, 32'd13);
        wait_result(1'b0, edges, reqs, dat);
        n_checks++; if ({edges, dat} !== {32'd33, 32'd143}) begin n_fail++; $display("[TB] FAIL reset_clears_b2b: got edges=%0d data=%h expected 33/0000008f", edges, dat); end
        consume();
    endtask

    initial begin
        test_reset();
        test_mul();
        test_back_to_back();
        test_div();
        test_special();
        test_gnt_stall();
        test_flush();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
